// File: rtl/mem_port_arbiter.sv
// Shares one word-wide memory port between instruction fetch and the data cache.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise data has fixed priority.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [31:0]      d_addr,
    input  logic [0:3][7:0]  d_wdata,
    output logic [0:3][7:0]  d_rdata,
    output logic             d_done,
    input  logic             i_req,
    input  logic [31:0]      i_addr,
    output logic [31:0]      i_rdata,
    output logic             i_done,
    output logic [31:0]      mem_addr,
    output logic [0:3][7:0]  mem_data_in,
    output logic             mem_write_en,
    input  logic [0:3][7:0]  mem_data_out,
    output logic             busy
);

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic OWN_D = 1'b0;
    localparam logic OWN_I = 1'b1;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             owner;
    logic             we_q;
    logic [CNT_W-1:0] cnt;
    logic             grant_c;
    logic             win_c;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic             last;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and grant decision
    always_comb begin
        state_next = state;
        grant_c    = 1'b0;
        win_c      = OWN_D;
        case (state)
            ST_IDLE: begin
                if (d_req || i_req) begin
                    grant_c    = 1'b1;
                    state_next = ST_ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    if (d_req && i_req) begin
                        win_c = (last == OWN_D) ? OWN_I : OWN_D;
                    end else begin
                        win_c = d_req ? OWN_D : OWN_I;
                    end
`else
                    win_c = d_req ? OWN_D : OWN_I;
`endif
                end
            end
            ST_ACCESS: begin
                if (cnt == CNT_W'(0)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request latch, memory drive, read capture and completion pulses
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            owner        <= OWN_D;
            we_q         <= 1'b0;
            cnt          <= CNT_W'(0);
            mem_addr     <= 32'h0;
            mem_data_in  <= '0;
            mem_write_en <= 1'b0;
            d_rdata      <= '0;
            i_rdata      <= 32'h0;
            d_done       <= 1'b0;
            i_done       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            d_done       <= 1'b0;
            i_done       <= 1'b0;
            mem_write_en <= 1'b0;
            busy         <= (state_next != ST_IDLE);

            if (grant_c) begin
                owner <= win_c;
                cnt   <= CNT_W'(MEM_LATENCY - 1);
                if (win_c == OWN_D) begin
                    we_q         <= d_we;
                    mem_addr     <= d_addr;
                    mem_data_in  <= d_wdata;
                    // strobe only covers the first access cycle
                    mem_write_en <= d_we;
                end else begin
                    we_q     <= 1'b0;
                    mem_addr <= i_addr;
                end
            end

            if (state == ST_ACCESS) begin
                if (cnt == CNT_W'(0)) begin
                    if (owner == OWN_D) begin
                        d_done <= 1'b1;
                        if (!we_q) begin
                            d_rdata <= mem_data_out;
                        end
                    end else begin
                        i_done  <= 1'b1;
                        i_rdata <= mem_data_out;
                    end
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Most recent grant winner, starts as fetch so the first tie goes to data
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            last <= OWN_I;
        end else if (grant_c) begin
            last <= win_c;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction table plus reset, tie and latency corner sequences.
module tb_mem_port_arbiter;

    logic             clk;
    logic             rst_b;
    logic             d_req;
    logic             d_we;
    logic [31:0]      d_addr;
    logic [0:3][7:0]  d_wdata;
    logic [0:3][7:0]  d_rdata;
    logic             d_done;
    logic             i_req;
    logic [31:0]      i_addr;
    logic [31:0]      i_rdata;
    logic             i_done;
    logic [31:0]      mem_addr;
    logic [0:3][7:0]  mem_data_in;
    logic             mem_write_en;
    logic [0:3][7:0]  mem_data_out;
    logic             busy;

    logic             l1_d_req;
    logic             l1_d_we;
    logic [31:0]      l1_d_addr;
    logic [0:3][7:0]  l1_d_wdata;
    logic [0:3][7:0]  l1_d_rdata;
    logic             l1_d_done;
    logic             l1_i_req;
    logic [31:0]      l1_i_addr;
    logic [31:0]      l1_i_rdata;
    logic             l1_i_done;
    logic [31:0]      l1_mem_addr;
    logic [0:3][7:0]  l1_mem_data_in;
    logic             l1_mem_write_en;
    logic [0:3][7:0]  l1_mem_data_out;
    logic             l1_busy;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.MEM_LATENCY(4)) u_dut (
        .clk(clk), .rst_b(rst_b),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write_en(mem_write_en),
        .mem_data_out(mem_data_out), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_b(rst_b),
        .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
        .d_rdata(l1_d_rdata), .d_done(l1_d_done),
        .i_req(l1_i_req), .i_addr(l1_i_addr), .i_rdata(l1_i_rdata), .i_done(l1_i_done),
        .mem_addr(l1_mem_addr), .mem_data_in(l1_mem_data_in), .mem_write_en(l1_mem_write_en),
        .mem_data_out(l1_mem_data_out), .busy(l1_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word memory shared by both instances; only the main instance writes
    assign mem_data_out    = mem[mem_addr[9:2]];
    assign l1_mem_data_out = mem[l1_mem_addr[9:2]];

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 32'h0;
        mem[4] = 32'h2008000A;
        mem[1] = 32'h12345678;
        forever begin
            @(posedge clk);
            if (mem_write_en) mem[mem_addr[9:2]] <= mem_data_in;
        end
    end

    always @(negedge clk) begin
        if (rst_b && d_done && i_done) begin
            errors++;
            $display("FAIL both_done: d_done and i_done high together at %0t", $time);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_b    = 1'b0;
        d_req    = 1'b0;
        i_req    = 1'b0;
        l1_d_req = 1'b0;
        l1_i_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One access from a single side; returns latency in cycles from the request edge
    task automatic run_txn(input logic side, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                           output int nwe, output int nacc, output logic [31:0] wd_seen,
                           output int wrong);
        lat = -1; rd = 32'h0; nwe = 0; nacc = 0; wd_seen = 32'h0; wrong = 0;
        d_we = we; d_addr = addr; d_wdata = wdata; i_addr = addr;
        if (side) i_req = 1'b1; else d_req = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (mem_write_en) begin
                nwe++;
                wd_seen = mem_data_in;
            end
            if (busy && !d_done && !i_done && mem_addr == addr) nacc++;
            if (side ? d_done : i_done) wrong++;
            if (side ? i_done : d_done) begin
                lat = k;
                rd  = side ? i_rdata : d_rdata;
                break;
            end
        end
        d_req = 1'b0;
        i_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        side;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int          lat, nwe, nacc, wrong, cd, ci, nd, ni, n;
        logic [31:0] rd, wd_seen, ird;
        logic [5:0]  seq;
        logic [5:0]  seq_exp;

        // side: 0 data, 1 fetch; exp is read data, or d_rdata left unchanged by a write
        vecs[0] = '{1'b1, 1'b0, 32'h10,  32'h0,        32'h2008000A};
        vecs[1] = '{1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b1, 32'h104, 32'h01020304, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 1'b0, 32'h104, 32'h0,        32'h01020304};
        vecs[5] = '{1'b0, 1'b0, 32'h10,  32'h0,        32'h2008000A};

        d_we = 1'b0; d_addr = 32'h0; d_wdata = '0; i_addr = 32'h0;
        l1_d_we = 1'b0; l1_d_addr = 32'h0; l1_d_wdata = '0; l1_i_addr = 32'h0;
        rst_b = 1'b0; d_req = 1'b0; i_req = 1'b0; l1_d_req = 1'b0; l1_i_req = 1'b0;

        #12;
        check("rst_done_we_busy", {29'h0, d_done, i_done, mem_write_en | busy}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_data_in", mem_data_in, 32'h0);
        check("rst_rdata", d_rdata | i_rdata, 32'h0);

        do_reset();

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].side, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    lat, rd, nwe, nacc, wd_seen, wrong);
            check($sformatf("txn%0d_latency", i), 32'(lat), 32'd5);
            check($sformatf("txn%0d_rdata", i), rd, vecs[i].exp);
            check($sformatf("txn%0d_we_cycles", i), 32'(nwe), {31'h0, vecs[i].we});
            check($sformatf("txn%0d_addr_cycles", i), 32'(nacc), 32'd4);
            check($sformatf("txn%0d_other_done", i), 32'(wrong), 32'd0);
            if (vecs[i].we) check($sformatf("txn%0d_wdata", i), wd_seen, vecs[i].wdata);
        end

        // Both sides held high: grant order recorded from done pulses
        do_reset();
        d_we = 1'b0; d_addr = 32'h100; i_addr = 32'h10;
        d_req = 1'b1; i_req = 1'b1;
        nd = 0; ni = 0; n = 0; seq = 6'h0;
        for (int k = 0; k < 200 && n < 6; k++) begin
            @(posedge clk);
            #1;
            if (d_done) begin
                seq = {seq[4:0], 1'b0}; n++; nd++;
                if (nd == 3) d_req = 1'b0;
            end
            if (i_done) begin
                seq = {seq[4:0], 1'b1}; n++; ni++;
                if (ni == 3) i_req = 1'b0;
            end
        end
        d_req = 1'b0; i_req = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        seq_exp = 6'b010101;
`else
        seq_exp = 6'b000111;
`endif
        check("tie_grant_count", 32'(n), 32'd6);
        check("tie_grant_order", {26'h0, seq}, {26'h0, seq_exp});
        @(posedge clk);
        #1;

        // Reset during the second access cycle of a write
        do_reset();
        d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hCAFEF00D; d_req = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_first_strobe", {31'h0, mem_write_en}, 32'd1);
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        #1;
        check("midrst_we_busy", {30'h0, mem_write_en, busy}, 32'd0);
        d_req = 1'b0;
        @(posedge clk);
        #1 rst_b = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (d_done || i_done) n++;
        end
        check("midrst_no_done", 32'(n), 32'd0);
        run_txn(1'b1, 1'b0, 32'h10, 32'h0, lat, rd, nwe, nacc, wd_seen, wrong);
        check("midrst_fetch_latency", 32'(lat), 32'd5);
        check("midrst_fetch_rdata", rd, 32'h2008000A);

        // Fetch arriving while a data read is in progress
        d_we = 1'b0; d_addr = 32'h100; i_addr = 32'h10; d_req = 1'b1;
        cd = -1; ci = -1; ird = 32'h0; rd = 32'h0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (d_done) begin
                cd = k; rd = d_rdata; d_req = 1'b0;
            end
            if (i_done) begin
                ci = k; ird = i_rdata; i_req = 1'b0;
                break;
            end
            if (k == 2) i_req = 1'b1;
        end
        d_req = 1'b0; i_req = 1'b0;
        check("busy_data_latency", 32'(cd), 32'd5);
        check("busy_data_rdata", rd, 32'hDEADBEEF);
        check("busy_fetch_after_done", 32'(ci - cd), 32'd6);
        check("busy_fetch_rdata", ird, 32'h2008000A);
        @(posedge clk);
        #1;

        // Minimum latency instance
        l1_i_addr = 32'h4; l1_i_req = 1'b1;
        lat = -1; rd = 32'h0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (l1_i_done) begin
                lat = k; rd = l1_i_rdata; l1_i_req = 1'b0;
                break;
            end
        end
        l1_i_req = 1'b0;
        check("lat1_latency", 32'(lat), 32'd2);
        check("lat1_rdata", rd, 32'h12345678);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
